imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl_if.sv | 39 +++
 rtl/imem_fetch_ctrl.sv | 105 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - program-load stream, instruction memory port and fetch-output bundle
interface imem_fetch_ctrl_if #(
  parameter int AW = 5
);
  // program-load stream
  logic          ld_valid;
  logic          ld_ready;
  logic [31:0]   ld_data;
  logic          ld_last;
  // instruction memory write and read ports
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_instr;
  // run control
  logic          start;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          halted;
  logic          err;
  // fetched-instruction handshake to decode
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;

  // fetch controller side
  modport master (
    input  ld_valid, ld_data, ld_last, mem_instr, start, redirect, redirect_pc, if_ready,
    output ld_ready, mem_we, mem_waddr, mem_wdata, mem_addr, halted, err, if_valid, if_instr, if_pc
  );

  // loader / memory / decode side
  modport slave (
    output ld_valid, ld_data, ld_last, mem_instr, start, redirect, redirect_pc, if_ready,
    input  ld_ready, mem_we, mem_waddr, mem_wdata, mem_addr, halted, err, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction memory loader and in-order fetch controller
module imem_fetch_ctrl #(
  parameter int          DEPTH      = 32,
  parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
  input logic               clk,
  input logic               rst_n,
  imem_fetch_ctrl_if.master bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] ld_cnt;
  logic [AW-1:0] pc;
  logic          if_valid_q;
  logic [31:0]   if_instr_q;
  logic [31:0]   if_pc_q;
  logic          halted_q;
  logic          err_q;
  logic          beat;

  assign bus.ld_ready  = (state == IDLE) || (state == LOAD);
  assign beat          = bus.ld_valid && bus.ld_ready;
  // a beat presented while reset is low must not reach the memory
  assign bus.mem_we    = beat && rst_n;
  assign bus.mem_waddr = ld_cnt;
  assign bus.mem_wdata = bus.ld_data;
  assign bus.mem_addr  = (state == RUN) ? {{(32-AW){1'b0}}, pc} : 32'd0;

  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.halted    = halted_q;
  assign bus.err       = err_q;

  // load / run / halt sequencing with all fetch outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ld_cnt     <= '0;
      pc         <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // start wins over a simultaneous first beat; that beat still lands in memory
          if (bus.start) begin
            state <= RUN;
            pc    <= '0;
          end else if (beat) begin
            ld_cnt <= ld_cnt + ONE;
            state  <= (bus.ld_last || ld_cnt == LAST_IDX) ? READY : LOAD;
          end
        end
        LOAD: begin
          if (beat) begin
            ld_cnt <= ld_cnt + ONE;
            if (bus.ld_last || ld_cnt == LAST_IDX) state <= READY;
          end
        end
        READY: begin
          if (bus.start) begin
            state <= RUN;
            pc    <= '0;
          end
        end
        RUN: begin
          if (bus.redirect) begin
            if_valid_q <= 1'b0;
            if (bus.redirect_pc >= DEPTH_W) begin
              state    <= HALT;
              halted_q <= 1'b1;
              err_q    <= 1'b1;
            end else begin
              pc <= bus.redirect_pc[AW-1:0];
            end
          end else if (if_valid_q && bus.if_ready && if_instr_q == HALT_INSTR) begin
            state      <= HALT;
            halted_q   <= 1'b1;
            if_valid_q <= 1'b0;
          end else if (!if_valid_q || bus.if_ready) begin
            if_instr_q <= bus.mem_instr;
            if_pc_q    <= {{(32-AW){1'b0}}, pc};
            if_valid_q <= 1'b1;
            pc         <= pc + ONE;
          end
        end
        HALT: begin
          halted_q   <= 1'b1;
          if_valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;
  localparam int AW = 5;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [31:0] mem_model [32];

  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.AW(AW)) bus();

  imem_fetch_ctrl #(.DEPTH(32), .HALT_INSTR(32'h00000073)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // instruction memory: written through the DUT write port, read combinationally
  always @(posedge clk) if (bus.mem_we) mem_model[bus.mem_waddr] <= bus.mem_wdata;
  assign bus.mem_instr = mem_model[bus.mem_addr[AW-1:0]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data = 32'hdeadbeef;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready: got %b want 1", bus.ld_ready); end
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr: got %h want 0", bus.if_instr); end
    checks++; if (bus.if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
    checks++; if (bus.halted !== 1'b0 || bus.err !== 1'b0) begin failures++; $display("FAIL reset_halted_err: got %b%b want 00", bus.halted, bus.err); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    bus.ld_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_load_last();
    logic [31:0] prog [3];
    exp_t e;
    prog[0] = 32'h00500093;
    prog[1] = 32'h00108113;
    prog[2] = 32'h00000073;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back('{a: 32'(i), d: prog[i]});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_data = prog[i];
      bus.ld_last = (i == 2);
      #1;
      checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL load_we beat %0d: got %b want 1", i, bus.mem_we); end
      e = exp_q.pop_front();
      checks++; if ({27'b0, bus.mem_waddr} !== e.a || bus.mem_wdata !== e.d) begin
        failures++; $display("FAIL load_write beat %0d: got %0d/%h want %0d/%h", i, bus.mem_waddr, bus.mem_wdata, e.a, e.d);
      end
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last = 1'b0;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL load_ready_after_last: got %b want 0", bus.ld_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL load_we_idle: got %b want 0", bus.mem_we); end
  endtask

  task automatic test_run_halt();
    exp_t e;
    exp_q.delete();
    exp_q.push_back('{a: 32'd0, d: 32'h00500093});
    exp_q.push_back('{a: 32'd1, d: 32'h00108113});
    exp_q.push_back('{a: 32'd2, d: 32'h00000073});
    @(negedge clk);
    bus.start = 1'b1;
    bus.if_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL run_latency: got if_valid %b want 0", bus.if_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      e = exp_q.pop_front();
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== e.a || bus.if_instr !== e.d) begin
        failures++; $display("FAIL run_fetch %0d: got v%b pc %0d instr %h want v1 pc %0d instr %h", i, bus.if_valid, bus.if_pc, bus.if_instr, e.a, e.d);
      end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.err !== 1'b0) begin
      failures++; $display("FAIL run_halt: got halted %b valid %b err %b want 1 0 0", bus.halted, bus.if_valid, bus.err);
    end
    @(negedge clk);
    #1;
    checks++; if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.mem_addr !== 32'h0) begin
      failures++; $display("FAIL halt_hold: got halted %b valid %b addr %h want 1 0 0", bus.halted, bus.if_valid, bus.mem_addr);
    end
  endtask

  task automatic test_load_overflow();
    exp_t e;
    int accepted;
    @(negedge clk);
    rst_n = 1'b0;
    bus.if_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    accepted = 0;
    for (int i = 0; i < 32; i++) exp_q.push_back('{a: 32'(i), d: 32'h1000 + 32'(i)});
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      bus.ld_valid = 1'b1;
      bus.ld_data = 32'h1000 + 32'(i);
      #1;
      checks++; if (bus.mem_we !== (i < 32)) begin failures++; $display("FAIL overflow_we beat %0d: got %b want %b", i, bus.mem_we, (i < 32)); end
      if (bus.mem_we === 1'b1) accepted++;
      if (i < 32) begin
        e = exp_q.pop_front();
        checks++; if ({27'b0, bus.mem_waddr} !== e.a || bus.mem_wdata !== e.d) begin
          failures++; $display("FAIL overflow_write beat %0d: got %0d/%h want %0d/%h", i, bus.mem_waddr, bus.mem_wdata, e.a, e.d);
        end
      end
    end
    @(negedge clk);
    bus.ld_valid = 1'b0;
    #1;
    checks++; if (accepted !== 32) begin failures++; $display("FAIL overflow_count: got %0d want 32", accepted); end
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL overflow_ready: got %b want 0", bus.ld_ready); end
  endtask

  task automatic test_stall();
    exp_t e;
    bit found;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back('{a: 32'(i), d: 32'h1000 + 32'(i)});
    @(negedge clk);
    bus.start = 1'b1;
    bus.if_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      #1;
      if (bus.if_valid === 1'b1) begin
        if (bus.if_pc === 32'd5) begin
          found = 1'b1;
          bus.if_ready = 1'b0;
        end else begin
          e = exp_q.pop_front();
          checks++; if (bus.if_pc !== e.a || bus.if_instr !== e.d) begin
            failures++; $display("FAIL stream pc: got %0d/%h want %0d/%h", bus.if_pc, bus.if_instr, e.a, e.d);
          end
        end
      end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL stall_reach_pc5: got %b want 1", found); end
    e = exp_q.pop_front();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== e.a || bus.if_instr !== e.d || bus.mem_addr !== 32'd6) begin
        failures++; $display("FAIL stall_hold %0d: got v%b pc %0d instr %h addr %0d want v1 pc %0d instr %h addr 6", n, bus.if_valid, bus.if_pc, bus.if_instr, bus.mem_addr, e.a, e.d);
      end
    end
    bus.if_ready = 1'b1;
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== e.a || bus.if_instr !== e.d) begin
      failures++; $display("FAIL stall_resume: got v%b pc %0d instr %h want v1 pc %0d instr %h", bus.if_valid, bus.if_pc, bus.if_instr, e.a, e.d);
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    exp_q.delete();
    exp_q.push_back('{a: 32'd9, d: 32'h1009});
    @(negedge clk);
    bus.if_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd9;
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL redirect_bubble: got %b want 0", bus.if_valid); end
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== e.a || bus.if_instr !== e.d) begin
      failures++; $display("FAIL redirect_target: got v%b pc %0d instr %h want v1 pc %0d instr %h", bus.if_valid, bus.if_pc, bus.if_instr, e.a, e.d);
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd40;
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.start = 1'b1;
    #1;
    checks++; if (bus.halted !== 1'b1 || bus.err !== 1'b1 || bus.if_valid !== 1'b0) begin
      failures++; $display("FAIL redirect_illegal: got halted %b err %b valid %b want 1 1 0", bus.halted, bus.err, bus.if_valid);
    end
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b1 || bus.err !== 1'b1 || bus.if_valid !== 1'b0) begin
      failures++; $display("FAIL halt_ignores_start: got halted %b err %b valid %b want 1 1 0", bus.halted, bus.err, bus.if_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    bit found;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.if_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      #1;
      if (bus.if_valid === 1'b1 && bus.if_pc === 32'd12) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL midrun_reach_pc12: got %b want 1", found); end
    rst_n = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data = 32'h00000bad;
    @(negedge clk);
    #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0) begin
      failures++; $display("FAIL midrun_reset_fetch: got v%b instr %h pc %h want 0 0 0", bus.if_valid, bus.if_instr, bus.if_pc);
    end
    checks++; if (bus.halted !== 1'b0 || bus.err !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.ld_ready !== 1'b1) begin
      failures++; $display("FAIL midrun_reset_ctrl: got halted %b err %b we %b addr %h ready %b want 0 0 0 0 1", bus.halted, bus.err, bus.mem_we, bus.mem_addr, bus.ld_ready);
    end
    exp_q.delete();
    exp_q.push_back('{a: 32'd0, d: 32'h1000});
    rst_n = 1'b1;
    bus.ld_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== e.a || bus.if_instr !== e.d) begin
      failures++; $display("FAIL midrun_restart: got v%b pc %0d instr %h want v1 pc %0d instr %h", bus.if_valid, bus.if_pc, bus.if_instr, e.a, e.d);
    end
  endtask

  initial begin
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.ld_last = 1'b0;
    bus.start = 1'b0;
    bus.if_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_load_last();
    test_run_halt();
    test_load_overflow();
    test_stall();
    test_redirect();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
